// File: rtl/register_scoreboard_pkg.sv
// Shared sizing for the register scoreboard: default widths and the
// derived width of the outstanding-reservation total.
package register_scoreboard_pkg;

   localparam int DEF_W_RD  = 5;
   localparam int DEF_N_REG = 2 ** DEF_W_RD;
   localparam int DEF_W_CNT = 2;

   // Width of the running total: up to N_REG counters of W_CNT bits each,
   // which always fits in W_RD + W_CNT bits.
   function automatic int pend_width(input int w_rd, input int w_cnt);
      return w_rd + w_cnt;
   endfunction

endpackage

// File: rtl/register_scoreboard_entry.sv
// One register's outstanding-write counter. Reports the writeback-bypassed
// view of the count and flags increments past saturation or decrements
// from zero so the top level can raise its sticky error.
module register_scoreboard_entry #(
   parameter int W_CNT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             flush,
   input  logic             zero_dis,
   output logic [W_CNT-1:0] eff,
   output logic             busy,
   output logic             sat,
   output logic             under_err,
   output logic             over_err
);

   localparam logic [W_CNT-1:0] CNT_MAX = '1;
   localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

   logic [W_CNT-1:0] cnt;
   logic             inc_g;
   logic             dec_g;

   // A disabled entry (hard-wired register 0) ignores both reserve and release.
   assign inc_g = inc & ~zero_dis;
   assign dec_g = dec & ~zero_dis;

   assign busy = (cnt != '0);
   assign sat  = (cnt == CNT_MAX);

   // Same-cycle writeback is visible to the hazard check before the counter moves.
   assign eff = (dec_g && busy) ? (cnt - CNT_ONE) : cnt;

   // Simultaneous reserve and release cancel, so neither can be a violation.
   assign over_err  = inc_g & ~dec_g & sat;
   assign under_err = dec_g & ~inc_g & ~busy;

   // Counter: flush wins, then a net +1 or -1 clamped at the ends of the range.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (flush || zero_dis) begin
         cnt <= '0;
      end else if (inc_g && !dec_g && !sat) begin
         cnt <= cnt + CNT_ONE;
      end else if (dec_g && !inc_g && busy) begin
         cnt <= cnt - CNT_ONE;
      end
   end

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard between decode and writeback. Decode reserves its
// destination (r0) and is told to stall through reserved_o while any field
// it reads still has a writer in flight; writeback releases reservations.
//
// Interface semantics: chk_v_i qualifies r0_i/r1_i/use_r1_i for the hazard
// check and reserved_o answers combinationally in the same cycle (it is
// forced to 0 when chk_v_i=0). reserved_o acts as the inverse of ready:
// decode may assert w_reserve_i only in a cycle where reserved_o=0; the
// block does not gate the reserve itself and instead records misuse in
// err_o. wb_v_i/wb_rd_i is an always-accepted release with no back-pressure.
module register_scoreboard
   import register_scoreboard_pkg::*;
#(
   parameter int W_RD     = DEF_W_RD,
   parameter int N_REG    = DEF_N_REG,
   parameter int W_CNT    = DEF_W_CNT,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  chk_v_i,
   input  logic [W_RD-1:0]       r0_i,
   input  logic [W_RD-1:0]       r1_i,
   input  logic                  use_r1_i,
   input  logic                  w_reserve_i,
   input  logic                  wb_v_i,
   input  logic [W_RD-1:0]       wb_rd_i,
   input  logic                  flush_i,
   output logic                  reserved_o,
   output logic [N_REG-1:0]      busy_o,
   output logic [W_RD+W_CNT-1:0] n_pend_o,
   output logic                  err_o
);

   localparam int               W_PEND  = pend_width(W_RD, W_CNT);
   localparam logic [W_CNT-1:0] CNT_MAX = '1;

   logic [N_REG-1:0] zero_vec;
   logic [N_REG-1:0] inc_vec;
   logic [N_REG-1:0] dec_vec;
   logic [N_REG-1:0] sat_vec;
   logic [N_REG-1:0] under_vec;
   logic [N_REG-1:0] over_vec;
   logic [W_CNT-1:0] eff_a [N_REG];

   logic [W_CNT-1:0] eff_r0;
   logic [W_CNT-1:0] eff_r1;
   logic             inc_acc;
   logic             dec_acc;
   logic             err_any;

   genvar k;
   generate
      for (k = 0; k < N_REG; k++) begin : g_entry
         assign zero_vec[k] = ZERO_REG && (k == 0);
         assign inc_vec[k]  = w_reserve_i && (r0_i == W_RD'(k)) && !zero_vec[k];
         assign dec_vec[k]  = wb_v_i && (wb_rd_i == W_RD'(k)) && !zero_vec[k];

         register_scoreboard_entry #(
            .W_CNT (W_CNT)
         ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[k]),
            .dec       (dec_vec[k]),
            .flush     (flush_i),
            .zero_dis  (zero_vec[k]),
            .eff       (eff_a[k]),
            .busy      (busy_o[k]),
            .sat       (sat_vec[k]),
            .under_err (under_vec[k]),
            .over_err  (over_vec[k])
         );
      end
   endgenerate

   assign eff_r0 = eff_a[r0_i];
   assign eff_r1 = eff_a[r1_i];

   // Stall if the destination or a read source still has a writer in flight;
   // the saturation term keeps decode from over-reserving its destination.
   assign reserved_o = chk_v_i &&
                       ((eff_r0 != '0) ||
                        (use_r1_i && (eff_r1 != '0)) ||
                        (eff_r0 == CNT_MAX));

   // Only moves the counters actually make are reflected in the total.
   assign inc_acc = |(inc_vec & ~dec_vec & ~sat_vec);
   assign dec_acc = |(dec_vec & ~inc_vec & busy_o);
   assign err_any = (|under_vec) | (|over_vec);

   // Running total and sticky error; flush empties the total but keeps err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_pend_o <= '0;
         err_o    <= 1'b0;
      end else if (flush_i) begin
         n_pend_o <= '0;
      end else begin
         n_pend_o <= n_pend_o + W_PEND'(inc_acc) - W_PEND'(dec_acc);
         err_o    <= err_o | err_any;
      end
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share the same stimulus. A behavioural per-register count model
// produces expectations that are queued when stimulus is driven and popped
// when the matching DUT output is sampled.
module tb_register_scoreboard;

   localparam int W_RD   = 5;
   localparam int N_REG  = 32;
   localparam int W_CNT  = 2;
   localparam int W_PEND = W_RD + W_CNT;
   localparam int C_MAX  = 3;
   localparam int W      = 32;

   logic              clk;
   logic              reset;
   logic              chk_v;
   logic [W_RD-1:0]   r0;
   logic [W_RD-1:0]   r1;
   logic              use_r1;
   logic              w_res;
   logic              wb_v;
   logic [W_RD-1:0]   wb_rd;
   logic              flush;

   logic              res_a,   res_b;
   logic [N_REG-1:0]  busy_a,  busy_b;
   logic [W_PEND-1:0] npend_a, npend_b;
   logic              err_a,   err_b;

   // Model state: index 0 = ZERO_REG=0 instance, index 1 = ZERO_REG=1 instance.
   int mcnt [2][N_REG];
   int mnp  [2];
   bit merr [2];

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   register_scoreboard #(
      .W_RD(W_RD), .N_REG(N_REG), .W_CNT(W_CNT), .ZERO_REG(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .chk_v_i(chk_v), .r0_i(r0), .r1_i(r1),
      .use_r1_i(use_r1), .w_reserve_i(w_res), .wb_v_i(wb_v), .wb_rd_i(wb_rd),
      .flush_i(flush), .reserved_o(res_a), .busy_o(busy_a),
      .n_pend_o(npend_a), .err_o(err_a)
   );

   register_scoreboard #(
      .W_RD(W_RD), .N_REG(N_REG), .W_CNT(W_CNT), .ZERO_REG(1'b1)
   ) dut_z (
      .clk(clk), .reset(reset), .chk_v_i(chk_v), .r0_i(r0), .r1_i(r1),
      .use_r1_i(use_r1), .w_reserve_i(w_res), .wb_v_i(wb_v), .wb_rd_i(wb_rd),
      .flush_i(flush), .reserved_o(res_b), .busy_o(busy_b),
      .n_pend_o(npend_b), .err_o(err_b)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset  = 1'b0;
      chk_v  = 1'b0;
      r0     = '0;
      r1     = '0;
      use_r1 = 1'b0;
      w_res  = 1'b0;
      wb_v   = 1'b0;
      wb_rd  = '0;
      flush  = 1'b0;
   end

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic compare_next(input string tag, input logic [W-1:0] act);
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check(tag, act, e);
   endtask

   // Model
   function automatic int m_eff(input int m, input int k);
      int rel;
      rel = (wb_v && (int'(wb_rd) == k) && (mcnt[m][k] != 0)) ? 1 : 0;
      return mcnt[m][k] - rel;
   endfunction

   function automatic bit m_res(input int m);
      int e0;
      int e1;
      e0 = m_eff(m, int'(r0));
      e1 = m_eff(m, int'(r1));
      return chk_v && ((e0 != 0) || (use_r1 && (e1 != 0)) || (e0 == C_MAX));
   endfunction

   task automatic m_clear();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < N_REG; k++) mcnt[m][k] = 0;
         mnp[m]  = 0;
         merr[m] = 1'b0;
      end
   endtask

   task automatic m_update(input int m);
      bit inc;
      bit dec;
      bit skip;
      if (flush) begin
         for (int k = 0; k < N_REG; k++) mcnt[m][k] = 0;
         mnp[m] = 0;
      end else begin
         for (int k = 0; k < N_REG; k++) begin
            skip = (m == 1) && (k == 0);
            inc  = w_res && (int'(r0) == k) && !skip;
            dec  = wb_v && (int'(wb_rd) == k) && !skip;
            if (inc && !dec) begin
               if (mcnt[m][k] == C_MAX) merr[m] = 1'b1;
               else begin mcnt[m][k]++; mnp[m]++; end
            end else if (dec && !inc) begin
               if (mcnt[m][k] == 0) merr[m] = 1'b1;
               else begin mcnt[m][k]--; mnp[m]--; end
            end
         end
      end
   endtask

   function automatic logic [W-1:0] m_busy(input int m);
      logic [W-1:0] b;
      b = '0;
      for (int k = 0; k < N_REG; k++) b[k] = (mcnt[m][k] != 0);
      return b;
   endfunction

   task automatic push_state();
      for (int m = 0; m < 2; m++) begin
         exp_q.push_back(m_busy(m));
         exp_q.push_back(W'(mnp[m]));
         exp_q.push_back(W'(merr[m]));
      end
   endtask

   task automatic compare_state();
      compare_next("busy",     W'(busy_a));
      compare_next("n_pend",   W'(npend_a));
      compare_next("err",      W'(err_a));
      compare_next("busy_z",   W'(busy_b));
      compare_next("n_pend_z", W'(npend_b));
      compare_next("err_z",    W'(err_b));
   endtask

   // Driver: one clock of stimulus, hazard check mid-cycle, state after the edge.
   task automatic cycle(input bit c, input int a0, input int a1, input bit u,
                        input bit w, input bit v, input int wr, input bit f);
      @(negedge clk);
      chk_v  = c;
      r0     = W_RD'(a0);
      r1     = W_RD'(a1);
      use_r1 = u;
      w_res  = w;
      wb_v   = v;
      wb_rd  = W_RD'(wr);
      flush  = f;
      #1;
      exp_q.push_back(W'(m_res(0)));
      exp_q.push_back(W'(m_res(1)));
      compare_next("reserved",   W'(res_a));
      compare_next("reserved_z", W'(res_b));
      @(posedge clk);
      m_update(0);
      m_update(1);
      #1;
      push_state();
      compare_state();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b0;
      chk_v  = 1'b1;
      r0     = W_RD'(3);
      r1     = '0;
      use_r1 = 1'b0;
      w_res  = 1'b0;
      wb_v   = 1'b0;
      wb_rd  = '0;
      flush  = 1'b0;
      #1;
      m_clear();
      exp_q.push_back(W'(m_res(0)));
      exp_q.push_back(W'(m_res(1)));
      compare_next("reserved_rst",   W'(res_a));
      compare_next("reserved_z_rst", W'(res_b));
      push_state();
      compare_state();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Stimulus
   initial begin
      do_reset();

      // Reserve r3, then a source read of r3 must stall.
      cycle(0, 3, 0, 0, 1, 0, 0, 0);
      cycle(1, 0, 3, 1, 0, 0, 0, 0);
      // Same-cycle writeback bypasses the hazard on r3.
      cycle(1, 3, 0, 0, 0, 1, 3, 0);
      cycle(1, 3, 3, 1, 0, 0, 0, 0);

      // Saturate r5, then force a fourth reserve.
      repeat (3) cycle(0, 5, 0, 0, 1, 0, 0, 0);
      cycle(1, 5, 0, 0, 0, 0, 0, 0);
      cycle(1, 5, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

      // Simultaneous reserve and release of r7 cancel.
      do_reset();
      cycle(0, 7, 0, 0, 1, 0, 0, 0);
      cycle(0, 7, 0, 0, 1, 1, 7, 0);

      // Flush discards a same-cycle reserve; a stale release then errors.
      cycle(0, 2, 0, 0, 1, 0, 0, 0);
      cycle(0, 4, 0, 0, 1, 0, 0, 0);
      cycle(0, 6, 0, 0, 1, 0, 0, 0);
      cycle(0, 8, 0, 0, 1, 1, 4, 1);
      cycle(0, 0, 0, 0, 0, 1, 2, 0);
      cycle(0, 9, 0, 0, 1, 0, 0, 1);
      cycle(1, 9, 0, 0, 0, 0, 0, 0);

      // Register 0 handling differs between the two instances.
      do_reset();
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 9, 0, 0, 1, 0, 0, 0);
      cycle(1, 1, 9, 0, 0, 0, 0, 0);
      cycle(1, 1, 9, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0, 0);

      // Random traffic, releases steered mostly toward pending registers.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int a0;
         int a1;
         int wr;
         bit c;
         bit u;
         bit w;
         bit v;
         bit f;
         a0 = $urandom_range(0, 15);
         a1 = $urandom_range(0, 15);
         c  = ($urandom_range(0, 3) != 0);
         u  = $urandom_range(0, 1);
         w  = ($urandom_range(0, 2) == 0);
         v  = $urandom_range(0, 1);
         f  = ($urandom_range(0, 40) == 0);
         wr = $urandom_range(0, 15);
         if ($urandom_range(0, 7) != 0) begin
            for (int j = 0; j < 16; j++) begin
               if (mcnt[0][(wr + j) % 16] != 0) begin
                  wr = (wr + j) % 16;
                  break;
               end
            end
         end
         cycle(c, a0, a1, u, w, v, wr, f);
      end

      // Reset mid-operation drops reservations; a late release errors.
      cycle(0, 11, 0, 0, 1, 0, 0, 0);
      do_reset();
      cycle(1, 11, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 11, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);

      // Report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
